mem_resp: RTL and testbench



---
 rtl/cpu_pkg.sv | 32 +++
 rtl/mem_array.sv | 66 ++++++
 rtl/mem_resp.sv | 134 +++++++++++++
 tb/tb_mem_resp.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU data-memory path:
//   - read/write encodings of the mrwen strobe (MEM_REN / MEM_WEN)
//   - default data word width and address width
//   - responder FSM state enum (mem_state_t)
//   - even-parity helper used when MEM_PARITY_EN is defined
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic MEM_REN   = 1'b0;
   localparam logic MEM_WEN   = 1'b1;

   localparam int   DEF_BUSW  = 32;
   localparam int   DEF_MINDW = 12;

   // Widest word the parity helper accepts; narrower words are zero-extended,
   // which does not change their parity.
   localparam int   MAX_BUSW  = 64;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } mem_state_t;

   // Even-parity bit: makes the total count of ones (data + parity) even.
   function automatic logic calc_parity(input logic [MAX_BUSW-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous word store for the data-memory responder.
// The read port is registered: the word addressed while i_re is high appears on
// o_rdata after the next rising edge and is held until the next read.
// Optional build macro: MEM_PARITY_EN adds one stored parity bit per word.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset (clears the read register only)
//   i_we     in   write enable
//   i_re     in   read enable
//   i_addr   in   word address (MINDW bits)
//   i_wdata  in   write data (BUSW bits)
//   o_rdata  out  registered read data (BUSW bits)
//   i_wpar   in   parity bit to store (MEM_PARITY_EN only)
//   o_rpar   out  registered parity of the last read (MEM_PARITY_EN only)
// -----------------------------------------------------------------------------
module mem_array #(
   parameter int BUSW  = 32,
   parameter int MINDW = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_we,
   input  logic             i_re,
   input  logic [MINDW-1:0] i_addr,
   input  logic [BUSW-1:0]  i_wdata,
`ifdef MEM_PARITY_EN
   input  logic             i_wpar,
   output logic             o_rpar,
`endif
   output logic [BUSW-1:0]  o_rdata
);

   // Storage is never reset so it maps onto block RAM.
   logic [BUSW-1:0] r_mem [2**MINDW];
`ifdef MEM_PARITY_EN
   logic            r_par [2**MINDW];
`endif

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
`ifdef MEM_PARITY_EN
         r_par[i_addr] <= i_wpar;
`endif
      end
   end

   // Output register: reset to zero, otherwise only loaded on a read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_rdata <= '0;
`ifdef MEM_PARITY_EN
         o_rpar  <= 1'b0;
`endif
      end else if (i_re) begin
         o_rdata <= r_mem[i_addr];
`ifdef MEM_PARITY_EN
         o_rpar  <= r_par[i_addr];
`endif
      end
   end

endmodule

// File: rtl/mem_resp.sv
// -----------------------------------------------------------------------------
// mem_resp
// Data-memory responder at the far end of the CPU memory port. Takes one
// read or write at a time, spends WAIT cycles in ACCESS, then completes in a
// single RESP cycle that pulses ack. Reads land on MemDbusIn during RESP and
// are held until the next read; writes commit at the end of RESP.
// Optional build macro: MEM_PARITY_EN (per-word even parity, perr/perr_inj).
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req         in   request, held with address/data/mrwen until ack
//   mrwen       in   access type (WEN = write, anything else = read)
//   MemInd      in   word address (MINDW bits)
//   MemDbusOut  in   write data (BUSW bits)
//   MemDbusIn   out  read data (BUSW bits)
//   ack         out  one-cycle completion pulse
//   busy        out  high whenever not IDLE
//   perr        out  parity mismatch of last read (MEM_PARITY_EN only)
//   perr_inj    in   inverts stored parity of a write (MEM_PARITY_EN only)
// -----------------------------------------------------------------------------
module mem_resp
   import cpu_pkg::*;
#(
   parameter int   BUSW  = DEF_BUSW,
   parameter int   MINDW = DEF_MINDW,
   parameter logic REN   = MEM_REN,
   parameter logic WEN   = MEM_WEN,
   parameter int   WAIT  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             mrwen,
   input  logic [MINDW-1:0] MemInd,
   input  logic [BUSW-1:0]  MemDbusOut,
   output logic [BUSW-1:0]  MemDbusIn,
   output logic             ack,
`ifdef MEM_PARITY_EN
   output logic             perr,
   input  logic             perr_inj,
`endif
   output logic             busy
);

   mem_state_t       r_state;
   mem_state_t       w_state_next;
   logic [3:0]       r_cnt;
   logic [MINDW-1:0] r_addr;
   logic             r_wr;
   logic [BUSW-1:0]  r_wdata;

   logic [MINDW-1:0] w_addr;
   logic             w_op_wr;
   logic             w_re;
   logic             w_we;
   logic [BUSW-1:0]  w_rdata;

   // ---------------- next-state / outputs ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (req) w_state_next = (WAIT > 0) ? S_ACCESS : S_RESP;
         S_ACCESS: if (r_cnt == 4'd1) w_state_next = S_RESP;
         S_RESP:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   assign ack  = (r_state == S_RESP);
   assign busy = (r_state != S_IDLE);

   // ---------------- state, counter, request latches ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_wr    <= 1'b0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE && req) begin
            r_addr  <= MemInd;
            r_wr    <= w_op_wr;
            r_wdata <= MemDbusOut;
            r_cnt   <= 4'(WAIT);
         end else if (r_state == S_ACCESS) begin
            r_cnt   <= r_cnt - 4'd1;
         end
      end
   end

   // The array read is registered, so it is issued on the edge that enters
   // RESP. With WAIT=0 that edge leaves IDLE before the latches are valid,
   // hence the bypass to the live request inputs while in IDLE.
   // A degenerate REN==WEN configuration never writes.
   assign w_addr  = (r_state == S_IDLE) ? MemInd : r_addr;
   assign w_op_wr = (r_state == S_IDLE) ? ((mrwen == WEN) && (REN != WEN)) : r_wr;

   // rst_n gating keeps a reset edge from loading read data or committing a write.
   assign w_re = rst_n && (w_state_next == S_RESP) && !w_op_wr;
   assign w_we = rst_n && (r_state == S_RESP) && r_wr;

`ifdef MEM_PARITY_EN
   logic w_wpar;
   logic w_rpar;

   assign w_wpar = calc_parity(MAX_BUSW'(r_wdata)) ^ perr_inj;
   // Read data and parity registers only change on a read, so the mismatch
   // holds until the next read completes; both reset to zero, so perr does too.
   assign perr   = calc_parity(MAX_BUSW'(w_rdata)) ^ w_rpar;
`endif

   mem_array #(
      .BUSW  (BUSW),
      .MINDW (MINDW)
   ) u_mem_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (w_addr),
      .i_wdata (r_wdata),
`ifdef MEM_PARITY_EN
      .i_wpar  (w_wpar),
      .o_rpar  (w_rpar),
`endif
      .o_rdata (w_rdata)
   );

   assign MemDbusIn = w_rdata;

endmodule

// File: tb/tb_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_mem_resp
// Directed bench for mem_resp: one instance with WAIT=2 (latency, reset abort,
// read-data hold, optional parity) and one with WAIT=0 (continuous req).
// -----------------------------------------------------------------------------
module tb_mem_resp;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // WAIT=2 instance
   logic        rst_n2 = 1'b0, req2 = 1'b0, mrwen2 = 1'b0;
   logic [11:0] ind2 = '0;
   logic [31:0] dout2 = '0, din2;
   logic        ack2, busy2;
   // WAIT=0 instance
   logic        rst_n0 = 1'b0, req0 = 1'b0, mrwen0 = 1'b0;
   logic [11:0] ind0 = '0;
   logic [31:0] dout0 = '0, din0;
   logic        ack0, busy0;
`ifdef MEM_PARITY_EN
   logic        perr2, perr0;
   logic        perr_inj2 = 1'b0, perr_inj0 = 1'b0;
   logic        perr_at_ack;
`endif

   int checks = 0;
   int errors = 0;

   mem_resp #(.BUSW(32), .MINDW(12), .REN(1'b0), .WEN(1'b1), .WAIT(2)) dut2 (
      .clk(clk), .rst_n(rst_n2), .req(req2), .mrwen(mrwen2), .MemInd(ind2),
      .MemDbusOut(dout2), .MemDbusIn(din2), .ack(ack2),
`ifdef MEM_PARITY_EN
      .perr(perr2), .perr_inj(perr_inj2),
`endif
      .busy(busy2)
   );

   mem_resp #(.BUSW(32), .MINDW(12), .REN(1'b0), .WEN(1'b1), .WAIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n0), .req(req0), .mrwen(mrwen0), .MemInd(ind0),
      .MemDbusOut(dout0), .MemDbusIn(din0), .ack(ack0),
`ifdef MEM_PARITY_EN
      .perr(perr0), .perr_inj(perr_inj0),
`endif
      .busy(busy0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction on the WAIT=2 instance, starting at a negedge in IDLE.
   // Checks latency (posedges to ack), busy and MemDbusIn at the ack cycle,
   // then drops req and waits one cycle so the FSM is back in IDLE.
   task automatic xact2(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] exp_din, input string tag);
      int n = 0;
      req2 = 1'b1; mrwen2 = w; ind2 = a; dout2 = d;
      do begin
         @(posedge clk); n++; @(negedge clk);
      end while (!ack2 && n < 20);
      chk({tag, "_lat"},  n,     3);
      chk({tag, "_busy"}, busy2, 1);
      chk({tag, "_din"},  din2,  exp_din);
`ifdef MEM_PARITY_EN
      perr_at_ack = perr2;
`endif
      $display("W2 %s %s addr=%h wdata=%h lat=%0d din=%h", tag, w ? "WR" : "RD", a, d, n, din2);
      req2 = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   // One transaction on the WAIT=0 instance with req held high throughout.
   task automatic step0(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_din, input string tag);
      int n = 0;
      req0 = 1'b1; mrwen0 = w; ind0 = a; dout0 = d;
      do begin
         @(posedge clk); n++; @(negedge clk);
      end while (!ack0 && n < 20);
      chk({tag, "_lat"}, n,    exp_lat);
      chk({tag, "_din"}, din0, exp_din);
      $display("W0 %s %s addr=%h wdata=%h lat=%0d din=%h", tag, w ? "WR" : "RD", a, d, n, din0);
   endtask

   initial begin
      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack",  ack2,  0);
      chk("rst_busy", busy2, 0);
      chk("rst_din",  din2,  32'h0);
`ifdef MEM_PARITY_EN
      chk("rst_perr", perr2, 0);
`endif
      rst_n2 = 1'b1;
      @(posedge clk); @(negedge clk);

      // ---------------- write then read, WAIT=2 ----------------
      xact2(1'b1, 12'h010, 32'hDEADBEEF, 32'h0,        "wr010");
      xact2(1'b0, 12'h010, 32'h0,        32'hDEADBEEF, "rd010");

      // ---------------- reset during ACCESS of a write ----------------
      xact2(1'b1, 12'h020, 32'h11111111, 32'hDEADBEEF, "pre020");
      req2 = 1'b1; mrwen2 = 1'b1; ind2 = 12'h020; dout2 = 32'h12345678;
      @(posedge clk); @(negedge clk);
      chk("abort_busy_in_access", busy2, 1);
      rst_n2 = 1'b0;               // req still high: reset must win
      @(posedge clk); @(negedge clk);
      chk("abort_busy", busy2, 0);
      chk("abort_ack",  ack2,  0);
      req2 = 1'b0; rst_n2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         chk("abort_no_ack", ack2, 0);
      end
      xact2(1'b0, 12'h020, 32'h0, 32'h11111111, "rd020");

      // ---------------- read data held through a write ----------------
      xact2(1'b1, 12'h030, 32'hA5A5A5A5, 32'h11111111, "wr030");
      xact2(1'b0, 12'h030, 32'h0,        32'hA5A5A5A5, "rd030");
      xact2(1'b1, 12'h040, 32'h0BADF00D, 32'hA5A5A5A5, "wr040");
      chk("hold_after_wr", din2, 32'hA5A5A5A5);

`ifdef MEM_PARITY_EN
      // ---------------- parity injection ----------------
      perr_inj2 = 1'b1;
      xact2(1'b1, 12'h050, 32'h00000001, 32'hA5A5A5A5, "wr050_inj");
      perr_inj2 = 1'b0;
      xact2(1'b0, 12'h050, 32'h0, 32'h00000001, "rd050_bad");
      chk("perr_set", perr_at_ack, 1);
      chk("perr_hold", perr2, 1);
      xact2(1'b1, 12'h050, 32'h00000001, 32'h00000001, "wr050_clean");
      xact2(1'b0, 12'h050, 32'h0, 32'h00000001, "rd050_good");
      chk("perr_clear", perr_at_ack, 0);
`endif

      // ---------------- WAIT=0, req held continuously ----------------
      rst_n0 = 1'b1;
      @(posedge clk); @(negedge clk);
      step0(1'b1, 12'h000, 32'hCAFEF00D, 1, 32'h0,        "w0_wr000");
      step0(1'b0, 12'h000, 32'h0,        2, 32'hCAFEF00D, "w0_rd000");
      step0(1'b1, 12'hFFF, 32'h13579BDF, 2, 32'hCAFEF00D, "w0_wrFFF");
      step0(1'b0, 12'hFFF, 32'h0,        2, 32'h13579BDF, "w0_rdFFF");
      step0(1'b0, 12'h000, 32'h0,        2, 32'hCAFEF00D, "w0_rd000b");
      req0 = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("w0_idle_busy", busy0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
